i2c_slave_ctrl: RTL and testbench

- Control FSM of the read-only I2C slave; sits directly upstream of the SDA output select stage and drives its 2-bit sda_mode.
- Consumes synchronized start/stop and SCL edge strobes, checks the received address byte, and sequences the RX shift register, TX shift register and TX FIFO pop.
- Owns the ACK/NACK timing and the master-ACK sampling for each transmitted byte.

---
 rtl/i2c_slave_ctrl.sv | 122 ++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// Control FSM for a read-only I2C slave: address check, ACK/NACK timing,
// TX byte sequencing and master-ACK sampling. Drives the SDA output mode select.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       rising_edge_found,
  input  logic       falling_edge_found,
  input  logic       sda_in,
  input  logic [7:0] rx_data,
  input  logic       fifo_empty,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       load_data,
  output logic       read_enable,
  output logic [1:0] sda_mode,
  output logic       busy
);

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrChk,
    StAckWait,
    StAckDrive,
    StNackWait,
    StNackDrive,
    StLoad,
    StTx,
    StMack,
    StMackHold,
    StWaitStop
  } state_e;

  localparam logic [1:0] ModeRelease = 2'b00;
  localparam logic [1:0] ModeAck     = 2'b01;
  localparam logic [1:0] ModeNack    = 2'b10;
  localparam logic [1:0] ModeTx      = 2'b11;

  state_e     state_q;
  logic [3:0] count_q;
  logic       addr_ok;
  logic       stop_ovr;
  logic       override;

  assign addr_ok  = (rx_data[7:1] == SLAVE_ADDR) && rx_data[0] && !fifo_empty;
  assign stop_ovr = stop_found && (state_q != StIdle);
  // Any cycle where reset, START or an effective STOP fires suppresses all strobes.
  assign override = rst || start_found || stop_ovr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= 4'd0;
    end else if (start_found) begin
      state_q <= StAddr;
      count_q <= 4'd0;
    end else if (stop_ovr) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StAddr: begin
          if (rising_edge_found) begin
            count_q <= count_q + 4'd1;
            if (count_q == 4'd7) state_q <= StAddrChk;
          end
        end
        StAddrChk:   state_q <= addr_ok ? StAckWait : StNackWait;
        StAckWait:   if (falling_edge_found) state_q <= StAckDrive;
        StAckDrive:  if (falling_edge_found) state_q <= StLoad;
        StNackWait:  if (falling_edge_found) state_q <= StNackDrive;
        StNackDrive: if (falling_edge_found) state_q <= StWaitStop;
        StLoad: begin
          state_q <= StTx;
          count_q <= 4'd0;
        end
        StTx: begin
          if (falling_edge_found) begin
            if (count_q < 4'd7) count_q <= count_q + 4'd1;
            else                state_q <= StMack;
          end
        end
        StMack: begin
          if (rising_edge_found) state_q <= sda_in ? StWaitStop : StMackHold;
        end
        StMackHold: begin
          if (falling_edge_found) state_q <= fifo_empty ? StWaitStop : StLoad;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  always_comb begin
    rx_enable   = 1'b0;
    tx_enable   = 1'b0;
    load_data   = 1'b0;
    read_enable = 1'b0;
    sda_mode    = ModeRelease;
    busy        = 1'b0;
    if (!rst) begin
      busy = (state_q != StIdle);
      case (state_q)
        StAckDrive:  sda_mode = ModeAck;
        StNackDrive: sda_mode = ModeNack;
        StLoad,
        StTx:        sda_mode = ModeTx;
        default:     sda_mode = ModeRelease;
      endcase
    end
    if (!override) begin
      rx_enable   = (state_q == StAddr) && rising_edge_found;
      tx_enable   = (state_q == StTx) && falling_edge_found && (count_q < 4'd7);
      load_data   = (state_q == StLoad);
      read_enable = (state_q == StLoad);
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: directed protocol scenarios plus randomized
// read transactions checked against a transaction-level expectation model.
module tb_i2c_slave_ctrl;

  localparam logic [6:0] SLAVE_ADDR = 7'b1111000;
  localparam logic [3:0] StbStart = 4'b1000;
  localparam logic [3:0] StbStop  = 4'b0100;
  localparam logic [3:0] StbRise  = 4'b0010;
  localparam logic [3:0] StbFall  = 4'b0001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_found = 1'b0;
  logic       stop_found = 1'b0;
  logic       rising_edge_found = 1'b0;
  logic       falling_edge_found = 1'b0;
  logic       sda_in = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       fifo_empty;
  logic       rx_enable, tx_enable, load_data, read_enable, busy;
  logic [1:0] sda_mode;

  int vectors = 0;
  int miscompares = 0;
  int rx_cnt = 0, tx_cnt = 0, load_cnt = 0, read_cnt = 0, pair_err = 0;
  int read_base = 0;
  int fifo_init = 0;

  i2c_slave_ctrl #(.SLAVE_ADDR(SLAVE_ADDR)) dut (
    .clk                (clk),
    .rst                (rst),
    .start_found        (start_found),
    .stop_found         (stop_found),
    .rising_edge_found  (rising_edge_found),
    .falling_edge_found (falling_edge_found),
    .sda_in             (sda_in),
    .rx_data            (rx_data),
    .fifo_empty         (fifo_empty),
    .rx_enable          (rx_enable),
    .tx_enable          (tx_enable),
    .load_data          (load_data),
    .read_enable        (read_enable),
    .sda_mode           (sda_mode),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  // Environment: RX shift register and a TX FIFO holding fifo_init entries.
  assign fifo_empty = (read_cnt - read_base) >= fifo_init;

  always @(posedge clk) begin
    if (rx_enable) rx_data <= {rx_data[6:0], sda_in};
    if (rx_enable) rx_cnt <= rx_cnt + 1;
    if (tx_enable) tx_cnt <= tx_cnt + 1;
    if (load_data) load_cnt <= load_cnt + 1;
    if (read_enable) read_cnt <= read_cnt + 1;
    if (load_data !== read_enable) pair_err <= pair_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe followed by two quiet cycles.
  task automatic drive(input logic [3:0] s, input logic sda);
    {start_found, stop_found, rising_edge_found, falling_edge_found} = s;
    sda_in = sda;
    tick();
    {start_found, stop_found, rising_edge_found, falling_edge_found} = 4'b0000;
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      drive(StbRise, b[i]);
      drive(StbFall, b[i]);
    end
  endtask

  // Full read transaction as seen from the bus; expectations derive from protocol rules.
  task automatic xact(input logic [7:0] addr_byte, input int fifo_n, input int nbytes,
                      input logic do_start);
    int   rx0, tx0, ld0, rd0, loaded;
    logic ack;
    read_base = read_cnt;
    fifo_init = fifo_n;
    ack    = (addr_byte[7:1] == SLAVE_ADDR) && addr_byte[0] && (fifo_n > 0);
    loaded = !ack ? 0 : (nbytes < fifo_n ? nbytes : fifo_n);
    rx0 = rx_cnt; tx0 = tx_cnt; ld0 = load_cnt; rd0 = read_cnt;
    if (do_start) drive(StbStart, 1'b1);
    chk("addr_mode", sda_mode, 0);
    chk("addr_busy", busy, 1);
    drive(StbFall, 1'b1);
    send_byte(addr_byte);
    chk("rx_pulses", rx_cnt - rx0, 8);
    chk("ack_mode", sda_mode, ack ? 1 : 2);
    drive(StbRise, 1'b1);
    chk("ack_mode_hi", sda_mode, ack ? 1 : 2);
    drive(StbFall, 1'b1);
    chk("first_load", load_cnt - ld0, loaded > 0 ? 1 : 0);
    chk("post_ack_mode", sda_mode, ack ? 3 : 0);
    for (int k = 0; k < loaded; k++) begin
      for (int b = 0; b < 8; b++) begin
        drive(StbRise, 1'b1);
        if (b == 3) chk("tx_mode", sda_mode, 3);
        drive(StbFall, 1'b1);
      end
      chk("tx_pulses", tx_cnt - tx0, 7 * (k + 1));
      chk("mack_mode", sda_mode, 0);
      drive(StbRise, (k + 1 < nbytes) ? 1'b0 : 1'b1);
      drive(StbFall, 1'b1);
      chk("next_mode", sda_mode, (k + 1 < loaded) ? 3 : 0);
    end
    drive(StbRise, 1'b0);
    drive(StbFall, 1'b0);
    chk("wait_stop_mode", sda_mode, 0);
    chk("wait_stop_busy", busy, 1);
    drive(StbStop, 1'b1);
    chk("stop_busy", busy, 0);
    chk("stop_mode", sda_mode, 0);
    chk("loads", load_cnt - ld0, loaded);
    chk("reads", read_cnt - rd0, loaded);
    chk("tx_total", tx_cnt - tx0, 7 * loaded);
    chk("load_read_pair", pair_err, 0);
  endtask

  initial begin
    int tx0, ld0;
    logic [6:0] a7;
    tick();
    tick();
    chk("rst_mode", sda_mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {rx_enable, tx_enable, load_data, read_enable}, 0);
    rst = 1'b0;
    tick();

    // Reset while transmitting.
    read_base = read_cnt; fifo_init = 1;
    drive(StbStart, 1'b1);
    drive(StbFall, 1'b1);
    send_byte(8'hF1);
    drive(StbRise, 1'b1);
    drive(StbFall, 1'b1);
    drive(StbRise, 1'b1);
    drive(StbFall, 1'b1);
    chk("pre_rst_mode", sda_mode, 3);
    tx0 = tx_cnt;
    rst = 1'b1;
    falling_edge_found = 1'b1;
    chk("rst_tx_gate", tx_enable, 0);
    tick();
    falling_edge_found = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_mode", sda_mode, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_strobes", {rx_enable, tx_enable, load_data, read_enable}, 0);
    drive(StbFall, 1'b1);
    chk("post_rst_no_tx", tx_cnt - tx0, 0);

    // Directed transactions.
    xact(8'hF1, 2, 1, 1'b1);
    xact(8'hA1, 3, 1, 1'b1);
    xact(8'hF0, 3, 1, 1'b1);
    xact(8'hF1, 0, 1, 1'b1);
    xact(8'hF1, 3, 2, 1'b1);
    xact(8'hF1, 1, 3, 1'b1);

    // Repeated START during TX after three shifts.
    read_base = read_cnt; fifo_init = 2;
    drive(StbStart, 1'b1);
    drive(StbFall, 1'b1);
    send_byte(8'hF1);
    drive(StbRise, 1'b1);
    drive(StbFall, 1'b1);
    tx0 = tx_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(StbRise, 1'b1);
      drive(StbFall, 1'b1);
    end
    chk("rs_shifts", tx_cnt - tx0, 3);
    {start_found, falling_edge_found} = 2'b11;
    chk("rs_tx_gate", tx_enable, 0);
    tick();
    {start_found, falling_edge_found} = 2'b00;
    tick();
    chk("rs_mode", sda_mode, 0);
    chk("rs_busy", busy, 1);
    chk("rs_no_extra_shift", tx_cnt - tx0, 3);
    xact(8'hF1, 2, 2, 1'b0);

    // STOP during ACK_DRIVE.
    read_base = read_cnt; fifo_init = 1;
    ld0 = load_cnt;
    drive(StbStart, 1'b1);
    drive(StbFall, 1'b1);
    send_byte(8'hF1);
    chk("sa_ack_mode", sda_mode, 1);
    drive(StbStop, 1'b1);
    chk("sa_mode", sda_mode, 0);
    chk("sa_busy", busy, 0);
    drive(StbFall, 1'b1);
    chk("sa_no_load", load_cnt - ld0, 0);

    // Randomized transactions.
    for (int n = 0; n < 30; n++) begin
      a7 = ($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 7'($urandom_range(0, 127));
      xact({a7, 1'($urandom_range(0, 1))}, int'($urandom_range(0, 3)),
           int'($urandom_range(1, 3)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
